// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Control stage in front of a modulo-MAX counter. Accepts a run request
//   (start value, tick count) over valid/ready. It loads the counter, then
//   enables it once per external tick strobe until the requested number of
//   steps is done or the run is aborted. It pulses done at the end and
//   reports how many times the counter wrapped during the run.
//
// Ports
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   req_valid   request present
//   req_ready   high only in IDLE
//   req_start   value loaded into the counter
//   req_ticks   number of enabled counter steps to perform
//   tick        step strobe; the counter advances only on tick cycles in RUN
//   abort       cancel the current run (honoured in LOAD/RUN only)
//   cnt_d       to counter d (holds the latched start value)
//   cnt_load    to counter load (one cycle, in LOAD)
//   cnt_enable  to counter enable (RUN && tick && !abort)
//   cnt_q       from counter q
//   busy        state != IDLE
//   done        one-cycle pulse at the end of a run
//   aborted     qualifies done: run ended by abort
//   wraps       wraps seen in the last/current run, saturating
module counter_sequencer #(
    parameter int WIDTH  = 4,
    parameter int MAX    = 12,
    parameter int CWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  req_start,
    input  logic [CWIDTH-1:0] req_ticks,
    input  logic              tick,
    input  logic              abort,
    output logic [WIDTH-1:0]  cnt_d,
    output logic              cnt_load,
    output logic              cnt_enable,
    input  logic [WIDTH-1:0]  cnt_q,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CWIDTH-1:0] wraps
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] QLAST = WIDTH'(MAX - 1);

    state_t            state;
    state_t            state_nx;
    logic [CWIDTH-1:0] ticks_l;
    logic [CWIDTH-1:0] remaining;
    logic              step;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = (req_ticks == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                state_nx = abort ? DONE : RUN;
            end
            RUN: begin
                // remaining is never 0 in RUN; the <= guards against a stuck run
                if (abort || (tick && remaining <= CWIDTH'(1))) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Combinational outputs: abort takes priority over a tick in the same cycle
    always_comb begin
        req_ready  = (state == IDLE);
        step       = (state == RUN) && tick && !abort;
        cnt_enable = step;
    end

    // Registered outputs and run bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_d     <= '0;
            cnt_load  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            wraps     <= '0;
            remaining <= '0;
            ticks_l   <= '0;
        end else begin
            cnt_load <= (state_nx == LOAD);
            busy     <= (state_nx != IDLE);
            done     <= (state_nx == DONE);

            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        cnt_d   <= req_start;
                        ticks_l <= req_ticks;
                        wraps   <= '0;
                        aborted <= 1'b0;
                    end
                end
                LOAD: begin
                    remaining <= ticks_l;
                    if (abort) begin
                        aborted <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end else if (step) begin
                        remaining <= remaining - CWIDTH'(1);
                        // counter steps from MAX-1 back to 0 on this enable
                        if (cnt_q == QLAST && wraps != '1) begin
                            wraps <= wraps + CWIDTH'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
